// File: rtl/branch_issue_queue.sv
// In-order issue queue for branch micro-ops feeding the port-0 branch execute stage.
// Optional macro BRANCH_IQ_BYPASS_EN: a fully ready op dispatched into an empty queue loads the output register directly.
module branch_issue_queue #(
  parameter int DEPTH  = 4,
  parameter int PTR_W  = 2,
  parameter int RTAG_W = 6
) (
  input  logic              iCLOCK,
  input  logic              inRESET,
  input  logic              iFREE_RESTART,
  input  logic              iDISP_VALID,
  input  logic [5:0]        iDISP_COMMIT_TAG,
  input  logic [4:0]        iDISP_CMD,
  input  logic [3:0]        iDISP_CC,
  input  logic [31:0]       iDISP_PC,
  input  logic              iDISP_SRC_VALID,
  input  logic [RTAG_W-1:0] iDISP_SRC_TAG,
  input  logic [31:0]       iDISP_SRC_DATA,
  input  logic              iDISP_FLAG_VALID,
  input  logic [RTAG_W-1:0] iDISP_FLAG_TAG,
  input  logic [4:0]        iDISP_FLAG_DATA,
  output logic              oDISP_FULL,
  input  logic              iWB_REG_VALID,
  input  logic [RTAG_W-1:0] iWB_REG_TAG,
  input  logic [31:0]       iWB_REG_DATA,
  input  logic              iWB_FLAG_VALID,
  input  logic [RTAG_W-1:0] iWB_FLAG_TAG,
  input  logic [4:0]        iWB_FLAG_DATA,
  output logic              oEX_BRANCH_VALID,
  output logic [5:0]        oEX_BRANCH_COMMIT_TAG,
  output logic [4:0]        oEX_BRANCH_CMD,
  output logic [3:0]        oEX_BRANCH_CC,
  output logic [4:0]        oEX_BRANCH_FLAG,
  output logic [31:0]       oEX_BRANCH_SOURCE,
  output logic [31:0]       oEX_BRANCH_PC,
  input  logic              iEX_BRANCH_LOCK
);

  localparam logic [PTR_W:0] FULL_COUNT = (PTR_W+1)'(DEPTH);

  logic [PTR_W-1:0]  r_head, r_tail;
  logic [PTR_W:0]    r_count;
  logic [DEPTH-1:0]  r_src_rdy, r_flag_rdy;
  logic [5:0]        r_ctag      [DEPTH];
  logic [4:0]        r_cmd       [DEPTH];
  logic [3:0]        r_cc        [DEPTH];
  logic [31:0]       r_pc        [DEPTH];
  logic [RTAG_W-1:0] r_src_tag   [DEPTH];
  logic [31:0]       r_src_data  [DEPTH];
  logic [RTAG_W-1:0] r_flag_tag  [DEPTH];
  logic [4:0]        r_flag_data [DEPTH];

  logic [DEPTH-1:0] w_src_hit, w_flag_hit;
  logic        w_full, w_empty, w_accept, w_out_free;
  logic        w_disp, w_push, w_pop, w_bypass;
  logic        w_disp_src_rdy, w_disp_flag_rdy;
  logic [31:0] w_disp_src;
  logic [4:0]  w_disp_flag;
  logic        w_head_src_rdy, w_head_flag_rdy;
  logic [31:0] w_head_src;
  logic [4:0]  w_head_flag;

  // NOTE: always_comb assigns every output a default first, so no path can leave a latch behind.
  always_comb begin
    w_src_hit  = '0;
    w_flag_hit = '0;
    for (int i = 0; i < DEPTH; i++) begin
      w_src_hit[i]  = !r_src_rdy[i]  && iWB_REG_VALID  && (iWB_REG_TAG  == r_src_tag[i]);
      w_flag_hit[i] = !r_flag_rdy[i] && iWB_FLAG_VALID && (iWB_FLAG_TAG == r_flag_tag[i]);
    end
  end

  assign w_full     = (r_count == FULL_COUNT);
  assign w_empty    = (r_count == '0);
  assign oDISP_FULL = w_full;
  assign w_accept   = oEX_BRANCH_VALID && !iEX_BRANCH_LOCK;
  assign w_out_free = !oEX_BRANCH_VALID || w_accept;
  assign w_disp     = iDISP_VALID && !w_full;

  // Dispatch operands with any same-cycle wakeup folded in.
  assign w_disp_src_rdy  = iDISP_SRC_VALID  || (iWB_REG_VALID  && iWB_REG_TAG  == iDISP_SRC_TAG);
  assign w_disp_src      = iDISP_SRC_VALID  ? iDISP_SRC_DATA  : iWB_REG_DATA;
  assign w_disp_flag_rdy = iDISP_FLAG_VALID || (iWB_FLAG_VALID && iWB_FLAG_TAG == iDISP_FLAG_TAG);
  assign w_disp_flag     = iDISP_FLAG_VALID ? iDISP_FLAG_DATA : iWB_FLAG_DATA;

  assign w_head_src_rdy  = r_src_rdy[r_head]  || w_src_hit[r_head];
  assign w_head_src      = w_src_hit[r_head]  ? iWB_REG_DATA  : r_src_data[r_head];
  assign w_head_flag_rdy = r_flag_rdy[r_head] || w_flag_hit[r_head];
  assign w_head_flag     = w_flag_hit[r_head] ? iWB_FLAG_DATA : r_flag_data[r_head];

  assign w_pop = w_out_free && !w_empty && w_head_src_rdy && w_head_flag_rdy;

`ifdef BRANCH_IQ_BYPASS_EN
  assign w_bypass = w_disp && w_empty && w_out_free && w_disp_src_rdy && w_disp_flag_rdy;
`else
  assign w_bypass = 1'b0;
`endif
  assign w_push = w_disp && !w_bypass;

  // NOTE: clocked state uses non-blocking assignments so every register sees pre-edge values.
  always_ff @(posedge iCLOCK or negedge inRESET) begin
    if (!inRESET) begin
      r_head     <= '0;
      r_tail     <= '0;
      r_count    <= '0;
      r_src_rdy  <= '0;
      r_flag_rdy <= '0;
    end else if (iFREE_RESTART) begin
      r_head     <= '0;
      r_tail     <= '0;
      r_count    <= '0;
      r_src_rdy  <= '0;
      r_flag_rdy <= '0;
    end else begin
      if (w_push) r_tail <= r_tail + PTR_W'(1);
      if (w_pop)  r_head <= r_head + PTR_W'(1);
      if (w_push && !w_pop)      r_count <= r_count + (PTR_W+1)'(1);
      else if (!w_push && w_pop) r_count <= r_count - (PTR_W+1)'(1);
      for (int i = 0; i < DEPTH; i++) begin
        if (w_push && r_tail == PTR_W'(i)) begin
          r_src_rdy[i]  <= w_disp_src_rdy;
          r_flag_rdy[i] <= w_disp_flag_rdy;
        end else begin
          if (w_src_hit[i])  r_src_rdy[i]  <= 1'b1;
          if (w_flag_hit[i]) r_flag_rdy[i] <= 1'b1;
        end
      end
    end
  end

  // NOTE: payload arrays carry no reset; occupancy lives entirely in count and the ready bits.
  always_ff @(posedge iCLOCK) begin
    for (int i = 0; i < DEPTH; i++) begin
      if (w_push && r_tail == PTR_W'(i)) begin
        r_ctag[i]      <= iDISP_COMMIT_TAG;
        r_cmd[i]       <= iDISP_CMD;
        r_cc[i]        <= iDISP_CC;
        r_pc[i]        <= iDISP_PC;
        r_src_tag[i]   <= iDISP_SRC_TAG;
        r_src_data[i]  <= w_disp_src;
        r_flag_tag[i]  <= iDISP_FLAG_TAG;
        r_flag_data[i] <= w_disp_flag;
      end else begin
        if (w_src_hit[i])  r_src_data[i]  <= iWB_REG_DATA;
        if (w_flag_hit[i]) r_flag_data[i] <= iWB_FLAG_DATA;
      end
    end
  end

  // Output register: holds while locked, reloads from bypass or queue head when free.
  always_ff @(posedge iCLOCK or negedge inRESET) begin
    if (!inRESET) begin
      oEX_BRANCH_VALID      <= 1'b0;
      oEX_BRANCH_COMMIT_TAG <= '0;
      oEX_BRANCH_CMD        <= '0;
      oEX_BRANCH_CC         <= '0;
      oEX_BRANCH_FLAG       <= '0;
      oEX_BRANCH_SOURCE     <= '0;
      oEX_BRANCH_PC         <= '0;
    end else if (iFREE_RESTART) begin
      oEX_BRANCH_VALID <= 1'b0;
    end else if (w_bypass) begin
      oEX_BRANCH_VALID      <= 1'b1;
      oEX_BRANCH_COMMIT_TAG <= iDISP_COMMIT_TAG;
      oEX_BRANCH_CMD        <= iDISP_CMD;
      oEX_BRANCH_CC         <= iDISP_CC;
      oEX_BRANCH_FLAG       <= w_disp_flag;
      oEX_BRANCH_SOURCE     <= w_disp_src;
      oEX_BRANCH_PC         <= iDISP_PC;
    end else if (w_pop) begin
      oEX_BRANCH_VALID      <= 1'b1;
      oEX_BRANCH_COMMIT_TAG <= r_ctag[r_head];
      oEX_BRANCH_CMD        <= r_cmd[r_head];
      oEX_BRANCH_CC         <= r_cc[r_head];
      oEX_BRANCH_FLAG       <= w_head_flag;
      oEX_BRANCH_SOURCE     <= w_head_src;
      oEX_BRANCH_PC         <= r_pc[r_head];
    end else if (w_accept) begin
      oEX_BRANCH_VALID <= 1'b0;
    end
  end

endmodule

// File: tb/tb_branch_issue_queue.sv
// Scoreboard bench for branch_issue_queue: a transaction-level queue model predicts issue order,
// operand values, valid and full; a negedge monitor compares whatever the DUT presents.
module tb_branch_issue_queue;

  localparam int DEPTH = 4;
`ifdef BRANCH_IQ_BYPASS_EN
  localparam bit BYP = 1'b1;
`else
  localparam bit BYP = 1'b0;
`endif

  typedef struct packed {
    logic [5:0]  ctag;
    logic [4:0]  cmd;
    logic [3:0]  cc;
    logic [31:0] pc;
    logic        src_rdy;
    logic [5:0]  src_tag;
    logic [31:0] src;
    logic        flag_rdy;
    logic [5:0]  flag_tag;
    logic [4:0]  flag;
  } op_t;

  logic iCLOCK = 1'b0, inRESET, iFREE_RESTART;
  logic iDISP_VALID, iDISP_SRC_VALID, iDISP_FLAG_VALID, oDISP_FULL;
  logic [5:0] iDISP_COMMIT_TAG, iDISP_SRC_TAG, iDISP_FLAG_TAG;
  logic [4:0] iDISP_CMD, iDISP_FLAG_DATA;
  logic [3:0] iDISP_CC;
  logic [31:0] iDISP_PC, iDISP_SRC_DATA;
  logic iWB_REG_VALID, iWB_FLAG_VALID;
  logic [5:0] iWB_REG_TAG, iWB_FLAG_TAG;
  logic [31:0] iWB_REG_DATA;
  logic [4:0] iWB_FLAG_DATA;
  logic oEX_BRANCH_VALID, iEX_BRANCH_LOCK;
  logic [5:0] oEX_BRANCH_COMMIT_TAG;
  logic [4:0] oEX_BRANCH_CMD, oEX_BRANCH_FLAG;
  logic [3:0] oEX_BRANCH_CC;
  logic [31:0] oEX_BRANCH_SOURCE, oEX_BRANCH_PC;

  branch_issue_queue #(.DEPTH(4), .PTR_W(2), .RTAG_W(6)) dut (
    .iCLOCK(iCLOCK), .inRESET(inRESET), .iFREE_RESTART(iFREE_RESTART),
    .iDISP_VALID(iDISP_VALID), .iDISP_COMMIT_TAG(iDISP_COMMIT_TAG), .iDISP_CMD(iDISP_CMD),
    .iDISP_CC(iDISP_CC), .iDISP_PC(iDISP_PC),
    .iDISP_SRC_VALID(iDISP_SRC_VALID), .iDISP_SRC_TAG(iDISP_SRC_TAG), .iDISP_SRC_DATA(iDISP_SRC_DATA),
    .iDISP_FLAG_VALID(iDISP_FLAG_VALID), .iDISP_FLAG_TAG(iDISP_FLAG_TAG), .iDISP_FLAG_DATA(iDISP_FLAG_DATA),
    .oDISP_FULL(oDISP_FULL),
    .iWB_REG_VALID(iWB_REG_VALID), .iWB_REG_TAG(iWB_REG_TAG), .iWB_REG_DATA(iWB_REG_DATA),
    .iWB_FLAG_VALID(iWB_FLAG_VALID), .iWB_FLAG_TAG(iWB_FLAG_TAG), .iWB_FLAG_DATA(iWB_FLAG_DATA),
    .oEX_BRANCH_VALID(oEX_BRANCH_VALID), .oEX_BRANCH_COMMIT_TAG(oEX_BRANCH_COMMIT_TAG),
    .oEX_BRANCH_CMD(oEX_BRANCH_CMD), .oEX_BRANCH_CC(oEX_BRANCH_CC), .oEX_BRANCH_FLAG(oEX_BRANCH_FLAG),
    .oEX_BRANCH_SOURCE(oEX_BRANCH_SOURCE), .oEX_BRANCH_PC(oEX_BRANCH_PC),
    .iEX_BRANCH_LOCK(iEX_BRANCH_LOCK)
  );

  always #5 iCLOCK = ~iCLOCK;

  int  n_checks = 0;
  int  n_err    = 0;
  op_t model_q[$];
  op_t exp_q[$];
  bit  m_out_valid = 1'b0;

  task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  function automatic logic [127:0] pack_op(input op_t o);
    return {44'd0, o.ctag, o.cmd, o.cc, o.flag, o.src, o.pc};
  endfunction

  function automatic logic [127:0] pack_dut();
    return {44'd0, oEX_BRANCH_COMMIT_TAG, oEX_BRANCH_CMD, oEX_BRANCH_CC, oEX_BRANCH_FLAG,
            oEX_BRANCH_SOURCE, oEX_BRANCH_PC};
  endfunction

  // Scoreboard monitor: whatever the DUT presents must be the oldest expected op.
  always @(negedge iCLOCK) begin
    if (inRESET) begin
      check("valid", oEX_BRANCH_VALID, m_out_valid);
      check("full", oDISP_FULL, model_q.size() == DEPTH);
      if (oEX_BRANCH_VALID) begin
        if (exp_q.size() == 0) begin
          n_checks++;
          n_err++;
          $display("FAIL sb_underflow: got tag %0h expected no op (t=%0t)", oEX_BRANCH_COMMIT_TAG, $time);
        end else begin
          check("op", pack_dut(), pack_op(exp_q[0]));
          if (!iEX_BRANCH_LOCK) void'(exp_q.pop_front());
        end
      end
    end
  end

  function automatic op_t wake(input op_t o);
    op_t r = o;
    if (!r.src_rdy && iWB_REG_VALID && iWB_REG_TAG == r.src_tag) begin
      r.src_rdy = 1'b1;
      r.src     = iWB_REG_DATA;
    end
    if (!r.flag_rdy && iWB_FLAG_VALID && iWB_FLAG_TAG == r.flag_tag) begin
      r.flag_rdy = 1'b1;
      r.flag     = iWB_FLAG_DATA;
    end
    return r;
  endfunction

  // Transaction model of one clock edge, evaluated on the inputs of the current cycle.
  task automatic model_step();
    op_t d, h;
    bit  acc, free, full, byp;
    int  sz;
    if (!inRESET || iFREE_RESTART) begin
      model_q.delete();
      exp_q.delete();
      m_out_valid = 1'b0;
      return;
    end
    sz   = model_q.size();
    full = (sz == DEPTH);
    acc  = m_out_valid && !iEX_BRANCH_LOCK;
    free = !m_out_valid || acc;
    for (int i = 0; i < sz; i++) begin
      h = wake(model_q[i]);
      model_q[i] = h;
    end
    d.ctag = iDISP_COMMIT_TAG; d.cmd = iDISP_CMD; d.cc = iDISP_CC; d.pc = iDISP_PC;
    d.src_rdy = iDISP_SRC_VALID; d.src_tag = iDISP_SRC_TAG;
    d.src = iDISP_SRC_VALID ? iDISP_SRC_DATA : 32'd0;
    d.flag_rdy = iDISP_FLAG_VALID; d.flag_tag = iDISP_FLAG_TAG;
    d.flag = iDISP_FLAG_VALID ? iDISP_FLAG_DATA : 5'd0;
    d = wake(d);
    if (sz > 0) h = model_q[0];
    if (free && sz > 0 && h.src_rdy && h.flag_rdy) begin
      exp_q.push_back(model_q.pop_front());
      m_out_valid = 1'b1;
    end else if (acc) begin
      m_out_valid = 1'b0;
    end
    if (iDISP_VALID && !full) begin
      byp = BYP && (sz == 0) && free && d.src_rdy && d.flag_rdy;
      if (byp) begin
        exp_q.push_back(d);
        m_out_valid = 1'b1;
      end else begin
        model_q.push_back(d);
      end
    end
  endtask

  // Runs the model for the current cycle, crosses the edge, returns 1 time unit after it.
  task automatic tick();
    @(negedge iCLOCK);
    #1;
    model_step();
    @(posedge iCLOCK);
    #1;
  endtask

  task automatic idle();
    iDISP_VALID = 1'b0; iWB_REG_VALID = 1'b0; iWB_FLAG_VALID = 1'b0; iFREE_RESTART = 1'b0;
  endtask

  task automatic disp(input logic [5:0] ctag, input logic [4:0] cmd, input logic sv,
                      input logic [5:0] stag, input logic [31:0] sdata, input logic fv,
                      input logic [5:0] ftag, input logic [4:0] fdata);
    iDISP_VALID = 1'b1; iDISP_COMMIT_TAG = ctag; iDISP_CMD = cmd;
    iDISP_CC = 4'($urandom); iDISP_PC = $urandom;
    iDISP_SRC_VALID = sv; iDISP_SRC_TAG = stag; iDISP_SRC_DATA = sdata;
    iDISP_FLAG_VALID = fv; iDISP_FLAG_TAG = ftag; iDISP_FLAG_DATA = fdata;
  endtask

  task automatic wb_reg(input logic [5:0] tag, input logic [31:0] data);
    iWB_REG_VALID = 1'b1; iWB_REG_TAG = tag; iWB_REG_DATA = data;
  endtask

  task automatic idle_ticks(input int n);
    for (int i = 0; i < n; i++) begin
      idle();
      tick();
    end
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    inRESET = 1'b0; iEX_BRANCH_LOCK = 1'b0;
    idle();
    disp(6'd0, 5'd0, 1'b0, 6'd0, 32'd0, 1'b0, 6'd0, 5'd0);
    iDISP_VALID = 1'b0;
    iWB_REG_TAG = '0; iWB_REG_DATA = '0; iWB_FLAG_TAG = '0; iWB_FLAG_DATA = '0;
    #12;
    check("rst_valid", oEX_BRANCH_VALID, 0);
    check("rst_full", oDISP_FULL, 0);
    check("rst_data", pack_dut(), 0);
    @(posedge iCLOCK); #1;
    inRESET = 1'b1;

    // Single ready op: visible 2 cycles after dispatch (1 with bypass), for exactly one cycle.
    disp(6'h05, 5'h03, 1'b1, 6'h00, 32'h1000, 1'b1, 6'h00, 5'h04);
    tick();
    idle();
    check("lat_first", oEX_BRANCH_VALID, BYP);
    tick();
    check("lat_second", oEX_BRANCH_VALID, !BYP);
    idle_ticks(3);

    // Wakeup: unrelated tag leaves it blocked, matching tag issues it next cycle.
    disp(6'h06, 5'h01, 1'b0, 6'h12, 32'h0, 1'b1, 6'h00, 5'h02);
    tick();
    for (int i = 0; i < 2; i++) begin
      idle(); wb_reg(6'h13, $urandom); tick();
    end
    idle(); wb_reg(6'h12, 32'hDEADBEEF); tick();
    idle();
    check("wake_latency", oEX_BRANCH_VALID, 1);
    idle_ticks(3);

    // In-order blocking: ready B waits behind non-ready A.
    disp(6'h0A, 5'h02, 1'b0, 6'h20, 32'h0, 1'b1, 6'h00, 5'h01);
    tick();
    disp(6'h0B, 5'h02, 1'b1, 6'h00, 32'h5555, 1'b1, 6'h00, 5'h03);
    tick();
    idle_ticks(3);
    idle(); wb_reg(6'h20, 32'hA5A5A5A5); tick();
    idle_ticks(4);

    // Full under lock: sixth dispatch is dropped.
    iEX_BRANCH_LOCK = 1'b1;
    for (int i = 0; i < 6; i++) begin
      disp(6'(8'h30 + i), 5'(i), 1'b1, 6'h00, $urandom, 1'b1, 6'h00, 5'($urandom));
      tick();
    end
    idle();
    check("full_locked", oDISP_FULL, 1);
    idle_ticks(2);
    iEX_BRANCH_LOCK = 1'b0;
    idle_ticks(8);

    // Free restart with a held output and three queued entries.
    iEX_BRANCH_LOCK = 1'b1;
    for (int i = 0; i < 4; i++) begin
      disp(6'(8'h38 + i), 5'(i), 1'b1, 6'h00, $urandom, 1'b1, 6'h00, 5'($urandom));
      tick();
    end
    idle_ticks(2);
    idle(); iFREE_RESTART = 1'b1; tick();
    idle();
    check("restart_valid", oEX_BRANCH_VALID, 0);
    check("restart_full", oDISP_FULL, 0);
    iEX_BRANCH_LOCK = 1'b0;
    idle_ticks(5);

    // Asynchronous reset while an op is presented.
    iEX_BRANCH_LOCK = 1'b1;
    disp(6'h3E, 5'h07, 1'b1, 6'h00, 32'h1234, 1'b1, 6'h00, 5'h09);
    tick();
    disp(6'h3F, 5'h08, 1'b1, 6'h00, 32'h4321, 1'b1, 6'h00, 5'h0A);
    tick();
    idle_ticks(2);
    #2;
    inRESET = 1'b0;
    #1;
    check("async_valid", oEX_BRANCH_VALID, 0);
    check("async_data", pack_dut(), 0);
    check("async_full", oDISP_FULL, 0);
    model_q.delete(); exp_q.delete(); m_out_valid = 1'b0;
    iEX_BRANCH_LOCK = 1'b0;
    idle_ticks(2);
    inRESET = 1'b1;
    idle_ticks(4);

    // Randomised traffic with small tag space to provoke wakeup hits.
    for (int c = 0; c < 800; c++) begin
      idle();
      if ($urandom_range(0, 99) < 60)
        disp(6'($urandom), 5'($urandom), 1'($urandom_range(0, 1)), 6'($urandom_range(0, 7)),
             $urandom, 1'($urandom_range(0, 1)), 6'($urandom_range(0, 7)), 5'($urandom));
      if ($urandom_range(0, 1) == 1) wb_reg(6'($urandom_range(0, 7)), $urandom);
      if ($urandom_range(0, 1) == 1) begin
        iWB_FLAG_VALID = 1'b1; iWB_FLAG_TAG = 6'($urandom_range(0, 7)); iWB_FLAG_DATA = 5'($urandom);
      end
      iEX_BRANCH_LOCK = ($urandom_range(0, 99) < 30);
      iFREE_RESTART   = ($urandom_range(0, 99) < 2);
      tick();
    end

    // Drain: sweep every tag on both wakeup buses.
    iEX_BRANCH_LOCK = 1'b0;
    for (int c = 0; c < 80; c++) begin
      idle();
      wb_reg(6'(c), $urandom);
      iWB_FLAG_VALID = 1'b1; iWB_FLAG_TAG = 6'(c); iWB_FLAG_DATA = 5'($urandom);
      tick();
    end
    idle_ticks(3);
    check("sb_leftover", exp_q.size(), 0);

    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

endmodule

// File: doc/branch_issue_queue.md
Name: branch_issue_queue

Overview:
- In-order issue queue for branch-class micro-ops, sitting directly upstream of the port-0 branch execute stage.
- Holds dispatched branch ops until their source operand and flag operand are ready, capturing both from the writeback wakeup buses.
- Presents the oldest ready op to the execute stage and honours its lock signal.
- All entries and the output register are flushed on a free restart.

Parameters:
DEPTH, 4, number of queue entries; power of two, minimum 2
PTR_W, 2, log2(DEPTH)
RTAG_W, 6, physical register / flag rename tag width

Ports:
iCLOCK  in  1  clock
inRESET  in  1  reset, asynchronous, active-low
iFREE_RESTART  in  1  synchronous flush of queue and output register
iDISP_VALID  in  1  dispatch request
iDISP_COMMIT_TAG  in  6  commit tag of the op
iDISP_CMD  in  5  branch command
iDISP_CC  in  4  condition code
iDISP_PC  in  32  op PC
iDISP_SRC_VALID  in  1  source operand already available
iDISP_SRC_TAG  in  RTAG_W  source rename tag, used when not valid
iDISP_SRC_DATA  in  32  source value, used when valid
iDISP_FLAG_VALID  in  1  flag operand already available
iDISP_FLAG_TAG  in  RTAG_W  flag rename tag
iDISP_FLAG_DATA  in  5  flag value
oDISP_FULL  out  1  queue full; dispatch is ignored while high
iWB_REG_VALID  in  1  register writeback wakeup
iWB_REG_TAG  in  RTAG_W  writeback tag
iWB_REG_DATA  in  32  writeback data
iWB_FLAG_VALID  in  1  flag writeback wakeup
iWB_FLAG_TAG  in  RTAG_W  flag writeback tag
iWB_FLAG_DATA  in  5  flag writeback data
oEX_BRANCH_VALID  out  1  op presented to execute stage
oEX_BRANCH_COMMIT_TAG  out  6  commit tag of presented op
oEX_BRANCH_CMD  out  5  command of presented op
oEX_BRANCH_CC  out  4  condition code of presented op
oEX_BRANCH_FLAG  out  5  flag operand of presented op
oEX_BRANCH_SOURCE  out  32  source operand of presented op
oEX_BRANCH_PC  out  32  PC of presented op
iEX_BRANCH_LOCK  in  1  execute stage busy; presented op is not accepted

Behaviour:
- Storage is a circular buffer with head and tail pointers of PTR_W bits that wrap modulo DEPTH, plus a count of PTR_W+1 bits.
- oDISP_FULL = (count == DEPTH), derived from registered count only. When full, dispatch is rejected even if a pop occurs in the same cycle.
- Dispatch: when iDISP_VALID && !oDISP_FULL, the entry at tail is written at the clock edge and tail is incremented.
  - Operand ready bits come from iDISP_*_VALID.
  - A wakeup whose tag matches a not-valid dispatch tag in the same cycle sets that ready bit and captures the wakeup data.
- Wakeup, every cycle:
  - Each occupied entry with a cleared SRC ready bit and iWB_REG_VALID && iWB_REG_TAG == src tag captures iWB_REG_DATA and sets the ready bit.
  - The flag operand wakes up the same way from the flag writeback bus.
  - Register and flag wakeups may hit the same entry in the same cycle; both are taken.
- Output register: oEX_* are registered.
  - An op is accepted when oEX_BRANCH_VALID && !iEX_BRANCH_LOCK.
  - While oEX_BRANCH_VALID && iEX_BRANCH_LOCK, all outputs hold unchanged.
- Issue:
  - The output register is free when it is not valid or is being accepted this cycle.
  - When the output register is free, count != 0, and the head entry has both ready bits set, the head entry (with any same-cycle wakeup applied) loads into the output register and head increments (pop).
  - Otherwise oEX_BRANCH_VALID is cleared if accepted, or held if not.
- Strict program order: a non-ready head blocks younger ready ops.
- Throughput: one issue per cycle while the lock is low.
- Latency, dispatch with ready operands into an empty queue: oEX_BRANCH_VALID is high two cycles after the dispatch cycle.
- Latency, last wakeup for a head op: valid one cycle after the wakeup cycle.
- Count: +1 on dispatch, -1 on pop; both in the same cycle leaves it unchanged.
- iFREE_RESTART has priority over dispatch, wakeup and issue. At the edge it clears head, tail, count, all ready bits and oEX_BRANCH_VALID. Data registers are don't-care.
- Reset values: oEX_BRANCH_VALID=0, all oEX_* data outputs=0, oDISP_FULL=0, pointers and count=0.
- Reset mid-operation discards all entries immediately (asynchronous).

Optional Feature:
- Macro: BRANCH_IQ_BYPASS_EN.
- Defined: when count == 0, the output register is free, and the dispatched op is fully ready (including same-cycle wakeup), the op loads straight into the output register at the dispatch edge. It is not written to the queue, and latency is 1 cycle. If the output register is occupied, the op enqueues normally.
- Not defined: every op passes through the queue, with minimum latency 2 cycles.

Test Plan:
- Single op, lock=0: dispatch tag 0x05, cmd 0x03, src valid 0x1000, flag valid 0x04 -> valid high exactly one cycle, two cycles later (one with bypass), carrying 0x05/0x1000/0x04.
- Wakeup: dispatch src tag 0x12 not valid; three cycles later iWB_REG 0x12 data 0xDEADBEEF -> issues one cycle after the wakeup with SOURCE 0xDEADBEEF; unrelated tag 0x13 causes no issue.
- In-order blocking: dispatch A (src not ready), then B (ready) -> B does not issue before A; after A's wakeup, A then B issue on consecutive cycles.
- Full plus lock: hold lock=1 and dispatch 6 ops -> first op held on outputs, oDISP_FULL high after 4 entries are buffered, 6th dispatch dropped; release lock -> remaining ops issue in order, one per cycle, and the dropped op never appears.
- Restart: 3 entries queued and output valid with lock=1, pulse iFREE_RESTART -> next cycle valid=0 and full=0, and no later issue of old tags.
- Async reset mid-issue: deassert inRESET while valid=1 -> outputs 0 immediately, and the queue is empty after release.
